// File: rtl/hw1p2_serial_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hw1p2_serial_tx_if                                                   |
// | Word handshake plus serial-stream status bundle for hw1p2_serial_tx. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface hw1p2_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             out;
  logic             busy;
  logic             last;

  modport master (
    output data,
    output valid,
    input  ready,
    input  out,
    input  busy,
    input  last
  );

  modport slave (
    input  data,
    input  valid,
    output ready,
    output out,
    output busy,
    output last
  );
endinterface
`default_nettype wire

// File: rtl/hw1p2_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hw1p2_serial_tx                                                      |
// | MSB-first word serialiser with idle-zero gap; define                 |
// | HW1P2_TX_PARITY_EN to append an even-parity bit after the data.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hw1p2_serial_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  hw1p2_serial_tx_if.slave tx
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_bit_init = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_bit_one  = CW'(1);
  localparam logic [3:0]    c_gap_init = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
`ifdef HW1P2_TX_PARITY_EN
    , S_PAR = 2'd3
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  // The MSB leaves straight through r_out, so only the remaining bits are held.
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-2:0] w_shift_next;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW-1:0]    w_bit_cnt_next;
  logic [3:0]       r_gap_cnt;
  logic [3:0]       w_gap_cnt_next;
  logic             r_out;
  logic             w_out_next;
  logic             r_last;
  logic             w_last_next;
  logic             r_busy;
`ifdef HW1P2_TX_PARITY_EN
  logic             r_par;
  logic             w_par_next;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_gap_cnt_next = r_gap_cnt;
    w_out_next     = 1'b0;
    w_last_next    = 1'b0;
`ifdef HW1P2_TX_PARITY_EN
    w_par_next     = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (tx.valid) begin
          w_shift_next   = tx.data[WIDTH-2:0];
          w_out_next     = tx.data[WIDTH-1];
          w_bit_cnt_next = c_bit_init;
          w_state_next   = S_SHIFT;
`ifdef HW1P2_TX_PARITY_EN
          w_par_next     = ^tx.data;
`endif
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt != '0) begin
          w_out_next     = r_shift[WIDTH-2];
          w_shift_next   = r_shift << 1;
          w_bit_cnt_next = r_bit_cnt - 1'b1;
          w_last_next    = (r_bit_cnt == c_bit_one);
        end else begin
`ifdef HW1P2_TX_PARITY_EN
          w_state_next = S_PAR;
          w_out_next   = r_par;
`else
          if (GAP > 0) begin
            w_state_next   = S_GAP;
            w_gap_cnt_next = c_gap_init;
          end else begin
            w_state_next = S_IDLE;
          end
`endif
        end
      end
`ifdef HW1P2_TX_PARITY_EN
      S_PAR: begin
        if (GAP > 0) begin
          w_state_next   = S_GAP;
          w_gap_cnt_next = c_gap_init;
        end else begin
          w_state_next = S_IDLE;
        end
      end
`endif
      S_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_next = S_IDLE;
        end else begin
          w_gap_cnt_next = r_gap_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= 4'd0;
      r_out     <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef HW1P2_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_gap_cnt <= w_gap_cnt_next;
      r_out     <= w_out_next;
      r_last    <= w_last_next;
      r_busy    <= (w_state_next != S_IDLE);
`ifdef HW1P2_TX_PARITY_EN
      r_par     <= w_par_next;
`endif
    end
  end

  assign tx.ready = (r_state == S_IDLE) && !reset;
  assign tx.out   = r_out;
  assign tx.busy  = r_busy;
  assign tx.last  = r_last;

endmodule
`default_nettype wire
